// File: rtl/fifo_rd_stream_pkg.sv
// Shared types for the FIFO read-side stream stage: skid-buffer occupancy states and data width.
package fifo_rd_stream_pkg;

  localparam int FIFO_WIDTH = 16;

  typedef enum logic [1:0] {BUF_EMPTY, BUF_ONE, BUF_TWO} rd_buf_state_e;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry skid buffer: head drives the stream, tail absorbs the word that lands during back-pressure.
module fifo_rd_skid_buf #(
  parameter int FIFO_WIDTH = fifo_rd_stream_pkg::FIFO_WIDTH,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [FIFO_WIDTH-1:0] push_data,
  output logic [FIFO_WIDTH-1:0] head_data,
  output logic                  head_valid,
  output logic [1:0]            occ
);
  import fifo_rd_stream_pkg::*;

  rd_buf_state_e         state_q, state_d;
  logic [FIFO_WIDTH-1:0] head_q, head_d;
  logic [FIFO_WIDTH-1:0] tail_q, tail_d;
  logic                  valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          head_d  = push_data;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          tail_d  = push_data;
          state_d = BUF_TWO;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = push_data;
          else      state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    valid_d = (state_d != BUF_EMPTY);
  end

  // The upstream credit check must never let a word arrive into a full buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      assert (!(state_q == BUF_TWO && push && !pop));
      assert (int'(state_q) <= BUF_DEPTH);
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
    end
  end

  assign head_data  = head_q;
  assign head_valid = valid_q;
  assign occ        = state_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the upstream FIFO into a valid/ready stream with a credit-checked 2-entry skid buffer.
// Optional word counter output enabled by defining FIFO_RD_STREAM_WORD_CNT_EN.
module fifo_rd_stream #(
  parameter int FIFO_WIDTH = fifo_rd_stream_pkg::FIFO_WIDTH,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  err_underflow
`ifdef FIFO_RD_STREAM_WORD_CNT_EN
  ,
  output logic [15:0]           word_cnt
`endif
);
  import fifo_rd_stream_pkg::*;

  logic       pend_q, pend_d;
  logic       err_q, err_d;
  logic       pop, push;
  logic [1:0] occ;
  logic [2:0] credit;

  fifo_rd_skid_buf #(
    .FIFO_WIDTH(FIFO_WIDTH),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (fifo_data_out),
    .head_data (m_data),
    .head_valid(m_valid),
    .occ       (occ)
  );

  // Words held plus the one in flight, less the one leaving now; m_ready feeds rd_en combinationally.
  always_comb begin
    pop        = m_valid & m_ready;
    push       = pend_q & ~fifo_underflow;
    credit     = {1'b0, occ} + {2'b0, pend_q} - {2'b0, pop};
    fifo_rd_en = ~rst & ~fifo_empty & (credit < 3'd2);
    pend_d     = fifo_rd_en;
    err_d      = err_q | (pend_q & fifo_underflow);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign err_underflow = err_q;

`ifdef FIFO_RD_STREAM_WORD_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 16'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign word_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: directed scenarios plus random traffic against a queue model.
// Define FIFO_RD_STREAM_WORD_CNT_EN to also exercise the word counter.
module tb_fifo_rd_stream;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_data_out = '0;
  logic         fifo_underflow = 1'b0;
  logic         fifo_rd_en;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         err_underflow;
`ifdef FIFO_RD_STREAM_WORD_CNT_EN
  logic [15:0]  word_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  // Upstream FIFO contents and the reference model of words owed to the consumer.
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  bit           pend_m = 1'b0;
  bit           err_m  = 1'b0;
  bit           rd_exp = 1'b0;
  logic [15:0]  cnt_m  = '0;
  bit           mon_en = 1'b0;

  // Stimulus-side observation counters.
  int cyc = 0, rd_cnt = 0, val_cnt = 0;
  int first_rd = -1, last_rd = -1, first_val = -1, last_val = -1;

  always #5 clk = ~clk;

  fifo_rd_stream #(.FIFO_WIDTH(W), .BUF_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_underflow(fifo_underflow),
    .fifo_rd_en    (fifo_rd_en),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .err_underflow (err_underflow)
`ifdef FIFO_RD_STREAM_WORD_CNT_EN
    ,
    .word_cnt      (word_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Clock-edge update of the model: consumer takes the head, an arriving read word joins the tail,
  // and the emulated FIFO answers the DUT's read request with next-cycle data.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      pend_m = 1'b0;
      err_m  = 1'b0;
      cnt_m  = '0;
    end else begin
      if (m_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        cnt_m = cnt_m + 16'd1;
      end
      if (pend_m) begin
        if (fifo_underflow) err_m = 1'b1;
        else                exp_q.push_back(fifo_data_out);
      end
      pend_m = rd_exp;
    end
    if (fifo_rd_en === 1'b1 && fifo_q.size() > 0) fifo_data_out <= fifo_q.pop_front();
  end

  // Mid-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int pop_m;
    #2;
    pop_m  = (m_ready && exp_q.size() > 0) ? 1 : 0;
    rd_exp = !rst && !fifo_empty && ((exp_q.size() + int'(pend_m) - pop_m) < 2);
    if (mon_en) begin
      checkOutput("fifo_rd_en", 32'(fifo_rd_en), 32'(rd_exp));
      checkOutput("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) checkOutput("m_data", 32'(m_data), 32'(exp_q[0]));
      checkOutput("err_underflow", 32'(err_underflow), 32'(err_m));
`ifdef FIFO_RD_STREAM_WORD_CNT_EN
      checkOutput("word_cnt", 32'(word_cnt), 32'(cnt_m));
`endif
    end
  end

  task automatic applyStimulus(input bit wr, input logic [15:0] word, input bit rdy,
                               input bit uf, input bit rs);
    @(negedge clk);
    rst            = rs;
    m_ready        = rdy;
    fifo_underflow = uf;
    if (wr) fifo_q.push_back(word);
    fifo_empty = (fifo_q.size() == 0);
    #3;
    cyc++;
    if (fifo_rd_en === 1'b1) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
    end
    if (m_valid === 1'b1) begin
      val_cnt++;
      if (first_val < 0) first_val = cyc;
      last_val = cyc;
    end
  endtask

  task automatic clearCounters();
    rd_cnt = 0; val_cnt = 0;
    first_rd = -1; last_rd = -1; first_val = -1; last_val = -1;
  endtask

  task automatic preload(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + 16'(i));
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with a non-empty FIFO: nothing may be read or presented.
    preload(3, 16'h00A0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
      mon_en = 1'b1;
      checkOutput("reset rd_en", 32'(fifo_rd_en), 32'd0);
      checkOutput("reset m_valid", 32'(m_valid), 32'd0);
      checkOutput("reset m_data", 32'(m_data), 32'd0);
      checkOutput("reset err", 32'(err_underflow), 32'd0);
    end
    fifo_q.delete();

    // Streaming eight preloaded words with the consumer always ready.
    clearCounters();
    preload(8, 16'h0001);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("stream rd count", 32'(rd_cnt), 32'd8);
    checkOutput("stream rd span", 32'(last_rd - first_rd), 32'd7);
    checkOutput("stream valid count", 32'(val_cnt), 32'd8);
    checkOutput("stream valid span", 32'(last_val - first_val), 32'd7);
    checkOutput("stream latency", 32'(first_val - first_rd), 32'd2);

    // Back-pressure: only two reads may be issued while the consumer stalls.
    clearCounters();
    preload(4, 16'h0001);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp rd count", 32'(rd_cnt), 32'd2);
    checkOutput("bp fifo left", 32'(fifo_q.size()), 32'd2);
    checkOutput("bp m_valid", 32'(m_valid), 32'd1);
    checkOutput("bp m_data held", 32'(m_data), 32'h0001);
    clearCounters();
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp drain count", 32'(val_cnt), 32'd4);
    checkOutput("bp drain span", 32'(last_val - first_val), 32'd3);
    checkOutput("bp drain rd count", 32'(rd_cnt), 32'd2);

    // Single word through an empty path.
    clearCounters();
    applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("single rd count", 32'(rd_cnt), 32'd1);
    checkOutput("single valid count", 32'(val_cnt), 32'd1);
    checkOutput("single empty after", 32'(m_valid), 32'd0);

    // Underflow reported in the data cycle: word dropped, sticky error until reset.
    clearCounters();
    applyStimulus(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("uf valid count", 32'(val_cnt), 32'd0);
    checkOutput("uf sticky", 32'(err_underflow), 32'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("uf cleared by reset", 32'(err_underflow), 32'd0);

    // Random traffic, occasional underflow flags and mid-stream resets.
    for (int i = 0; i < 1500; i++) begin
      bit rs;
      rs = ($urandom_range(149) == 0);
      if (rs) fifo_q.delete();
      applyStimulus(($urandom_range(1) == 1), 16'($urandom), ($urandom_range(3) != 0),
                    ($urandom_range(199) == 0), rs);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("drain m_valid", 32'(m_valid), 32'd0);
    checkOutput("drain fifo empty", 32'(fifo_q.size()), 32'd0);

`ifdef FIFO_RD_STREAM_WORD_CNT_EN
    // Counter wraps after 0x10000 handshakes.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 32'h10002; i++) applyStimulus(1'b1, 16'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("word_cnt wrap", 32'(word_cnt), 32'h0002);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
